// File: rtl/hamm_pkg.sv
// Shared widths, FSM state and result payload for the (7,4) Hamming decode scheduler.
package hamm_pkg;

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SYN_W  = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SYN_W-1:0]  syn;
    logic              src;
  } res_t;

endpackage

// File: rtl/hamm_decoder.sv
// Combinational (7,4) Hamming SEC decoder; codeword bit k lives at index k-1.
module hamm_decoder
  import hamm_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [DATA_W-1:0] o_data,
  output logic [SYN_W-1:0]  o_syn
);

  logic w_s1, w_s2, w_s4;

  assign w_s1  = i_code[0] ^ i_code[2] ^ i_code[4] ^ i_code[6];
  assign w_s2  = i_code[1] ^ i_code[2] ^ i_code[5] ^ i_code[6];
  assign w_s4  = i_code[3] ^ i_code[4] ^ i_code[5] ^ i_code[6];
  assign o_syn = {w_s4, w_s2, w_s1};

  // Only data positions need correcting; a parity-bit syndrome leaves data as received.
  assign o_data[3] = i_code[6] ^ (o_syn == SYN_W'(7));
  assign o_data[2] = i_code[5] ^ (o_syn == SYN_W'(6));
  assign o_data[1] = i_code[4] ^ (o_syn == SYN_W'(5));
  assign o_data[0] = i_code[2] ^ (o_syn == SYN_W'(3));

endmodule

// File: rtl/hamm_rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer advances only on an accepted grant.
module hamm_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic       o_grant
);

  logic r_last;
  logic w_grant;

  always_comb begin
    w_grant = i_valid[1];
    if (&i_valid) w_grant = ~r_last;
  end

  // Reset value 1 lets ch0 win the first contested cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_accept) begin
      r_last <= w_grant;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/hamm_dec_sched.sv
// Two-channel round-robin scheduler over one shared Hamming decoder with a registered result.
// Optional per-channel corrected-error counters are built when HAMM_ERR_STATS_EN is defined.
module hamm_dec_sched
  import hamm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ch0_valid,
  input  logic [CODE_W-1:0] ch0_code,
  output logic              ch0_ready,
  input  logic              ch1_valid,
  input  logic [CODE_W-1:0] ch1_code,
  output logic              ch1_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SYN_W-1:0]  out_syn,
  output logic              out_src,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_cnt0,
  output logic [CNT_W-1:0]  err_cnt1
);

  state_e            r_state;
  logic              r_out_valid;
  res_t              r_res;

  logic              w_can_load;
  logic              w_any_valid;
  logic              w_accept;
  logic              w_grant;
  logic [CODE_W-1:0] w_code;
  logic [DATA_W-1:0] w_data;
  logic [SYN_W-1:0]  w_syn;
  res_t              w_res;

  assign w_any_valid = ch0_valid | ch1_valid;
  assign w_can_load  = (r_state == EMPTY) | out_ready;
  assign w_accept    = w_can_load & w_any_valid;
  assign ch0_ready   = w_can_load & ~w_grant;
  assign ch1_ready   = w_can_load & w_grant;
  assign w_code      = w_grant ? ch1_code : ch0_code;

  hamm_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_valid  ({ch1_valid, ch0_valid}),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  hamm_decoder u_dec (
    .i_code (w_code),
    .o_data (w_data),
    .o_syn  (w_syn)
  );

  assign w_res = '{data: w_data, syn: w_syn, src: w_grant};

  // Output register FSM: FULL holds its result until out_ready, then reloads or drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_res       <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_any_valid) begin
            r_state     <= FULL;
            r_out_valid <= 1'b1;
            r_res       <= w_res;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (w_any_valid) begin
              r_out_valid <= 1'b1;
              r_res       <= w_res;
            end else begin
              r_state     <= EMPTY;
              r_out_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_res.data;
  assign out_syn   = r_res.syn;
  assign out_src   = r_res.src;

`ifdef HAMM_ERR_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  logic             w_err;

  assign w_err = w_accept & (w_syn != '0);

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_err) begin
      if (!w_grant && (r_cnt0 != CNT_MAX)) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (w_grant && (r_cnt1 != CNT_MAX))  r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign err_cnt0 = r_cnt0;
  assign err_cnt1 = r_cnt1;
`else
  logic w_unused_clr;

  assign w_unused_clr = err_clr;
  assign err_cnt0     = '0;
  assign err_cnt1     = '0;
`endif

endmodule

// File: tb/tb_hamm_dec_sched.sv
// Randomized bench for hamm_dec_sched against a behavioural scheduler/decoder model.
module tb_hamm_dec_sched;

  localparam int unsigned CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAMM_ERR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ch0_valid = 1'b0, ch1_valid = 1'b0;
  logic [6:0]       ch0_code = '0, ch1_code = '0;
  logic             out_ready = 1'b0, err_clr = 1'b0;
  logic             ch0_ready, ch1_ready, out_valid, out_src;
  logic [3:0]       out_data;
  logic [2:0]       out_syn;
  logic [CNT_W-1:0] err_cnt0, err_cnt1;

  int total = 0;
  int bad   = 0;

  hamm_dec_sched #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ch0_valid(ch0_valid), .ch0_code(ch0_code), .ch0_ready(ch0_ready),
    .ch1_valid(ch1_valid), .ch1_code(ch1_code), .ch1_ready(ch1_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_syn(out_syn), .out_src(out_src),
    .err_clr(err_clr), .err_cnt0(err_cnt0), .err_cnt1(err_cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Syndrome of a Hamming code is the XOR of the positions of all set bits.
  function automatic void model_dec(input logic [6:0] c, output logic [3:0] d, output logic [2:0] s);
    logic [7:0] v;
    logic [2:0] syn;
    v   = {c, 1'b0};
    syn = '0;
    for (int k = 1; k < 8; k++) if (v[k]) syn ^= 3'(k);
    if (syn != 3'd0) v[syn] = ~v[syn];
    d = {v[7], v[6], v[5], v[3]};
    s = syn;
  endfunction

  // ---------------- model + per-cycle compare ----------------
  bit         m_known = 1'b0;
  bit         m_valid, m_last, m_src;
  logic [3:0] m_data;
  logic [2:0] m_syn;
  int         m_cnt0, m_cnt1;
  bit         e_any, e_g, e_cl, e_acc;
  logic [3:0] e_d;
  logic [2:0] e_s;

  always @(negedge clk) begin
    e_any = ch0_valid || ch1_valid;
    e_g   = (ch0_valid && ch1_valid) ? !m_last : ch1_valid;
    e_cl  = !m_valid || out_ready;
    e_acc = e_cl && e_any;
    if (m_known) begin
      chk("out_valid", int'(out_valid), int'(m_valid));
      if (m_valid) begin
        chk("out_data", int'(out_data), int'(m_data));
        chk("out_syn", int'(out_syn), int'(m_syn));
        chk("out_src", int'(out_src), int'(m_src));
      end
      chk("err_cnt0", int'(err_cnt0), m_cnt0);
      chk("err_cnt1", int'(err_cnt1), m_cnt1);
      if (!rst && e_any) begin
        chk("ch0_ready", int'(ch0_ready), int'(e_cl && !e_g));
        chk("ch1_ready", int'(ch1_ready), int'(e_cl && e_g));
      end
      chk("ready_excl", int'(ch0_ready && ch1_ready), 0);
    end
    if (rst) begin
      m_known = 1'b1;
      m_valid = 1'b0; m_data = '0; m_syn = '0; m_src = 1'b0;
      m_last  = 1'b1; m_cnt0 = 0; m_cnt1 = 0;
    end else if (m_known) begin
      model_dec(e_g ? ch1_code : ch0_code, e_d, e_s);
      if (STATS) begin
        if (err_clr) begin
          m_cnt0 = 0; m_cnt1 = 0;
        end else if (e_acc && e_s != 3'd0) begin
          if (!e_g && m_cnt0 < CNT_MAX) m_cnt0++;
          if (e_g && m_cnt1 < CNT_MAX)  m_cnt1++;
        end
      end
      if (e_cl) begin
        if (e_acc) begin
          m_valid = 1'b1; m_data = e_d; m_syn = e_s; m_src = e_g; m_last = e_g;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] pd;
    logic [2:0] ps;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_syn", int'(out_syn), 0);
    chk("rst_src", int'(out_src), 0);
    chk("rst_cnt0", int'(err_cnt0), 0);
    chk("rst_cnt1", int'(err_cnt1), 0);

    model_dec(7'h75, pd, ps);
    chk("model_75_data", int'(pd), 11);
    chk("model_75_syn", int'(ps), 6);
    model_dec(7'h54, pd, ps);
    chk("model_54_data", int'(pd), 11);
    chk("model_54_syn", int'(ps), 1);

    // clean word on ch0
    ch0_valid = 1'b1; ch0_code = 7'h55; out_ready = 1'b1;
    tick();
    ch0_valid = 1'b0;
    chk("clean_valid", int'(out_valid), 1);
    chk("clean_data", int'(out_data), 11);
    chk("clean_syn", int'(out_syn), 0);
    chk("clean_src", int'(out_src), 0);
    chk("clean_cnt0", int'(err_cnt0), 0);

    // single-bit error on ch1 (bit 6)
    ch1_valid = 1'b1; ch1_code = 7'h75;
    tick();
    ch1_valid = 1'b0;
    chk("corr_data", int'(out_data), 11);
    chk("corr_syn", int'(out_syn), 6);
    chk("corr_src", int'(out_src), 1);
    chk("corr_cnt1", int'(err_cnt1), STATS ? 1 : 0);

    // fairness: both valid, alternating sources
    ch0_valid = 1'b1; ch0_code = 7'h55;
    ch1_valid = 1'b1; ch1_code = 7'h2A;
    #1;
    chk("fair_first_r0", int'(ch0_ready), 1);
    chk("fair_first_r1", int'(ch1_ready), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fair_src", int'(out_src), i % 2);
      chk("fair_data", int'(out_data), (i % 2 == 0) ? 11 : 4);
    end

    // backpressure while FULL
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_r0", int'(ch0_ready), 0);
      chk("bp_r1", int'(ch1_ready), 0);
      tick();
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data", int'(out_data), 4);
      chk("bp_src", int'(out_src), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_r0", int'(ch0_ready), 1);
    tick();
    chk("bp_rel_src", int'(out_src), 0);
    chk("bp_rel_data", int'(out_data), 11);
    ch0_valid = 1'b0; ch1_valid = 1'b0;

    // saturation and clear priority
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    ch0_valid = 1'b1; ch0_code = 7'h54;
    repeat (5) tick();
    chk("sat_cnt0", int'(err_cnt0), STATS ? 3 : 0);
    chk("sat_syn", int'(out_syn), 1);
    chk("sat_data", int'(out_data), 11);
    err_clr = 1'b1;
    tick();
    chk("clr_cnt0", int'(err_cnt0), 0);
    err_clr = 1'b0; ch0_valid = 1'b0;

    // reset while FULL and stalled
    ch1_valid = 1'b1; ch1_code = 7'h75;
    tick();
    out_ready = 1'b0;
    repeat (2) tick();
    chk("mid_valid", int'(out_valid), 1);
    chk("mid_cnt1", int'(err_cnt1), STATS ? 1 : 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_cnt0", int'(err_cnt0), 0);
    chk("mid_rst_cnt1", int'(err_cnt1), 0);
    rst = 1'b0; ch0_valid = 1'b1; ch0_code = 7'h55; out_ready = 1'b1;
    #1;
    chk("mid_r0", int'(ch0_ready), 1);
    chk("mid_r1", int'(ch1_ready), 0);
    tick();
    chk("mid_src", int'(out_src), 0);
    chk("mid_out_valid", int'(out_valid), 1);
    ch0_valid = 1'b0; ch1_valid = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ch0_valid = 1'($urandom_range(0, 1));
      ch1_valid = 1'($urandom_range(0, 1));
      ch0_code  = 7'($urandom);
      ch1_code  = 7'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      err_clr   = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; ch0_valid = 1'b0; ch1_valid = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
